lsb_mem_responder: RTL and testbench

- Memory-side responder for the LSB data request interface (need_data / is_write / data_addr / data_in / work_type in; data_handle / data_ready / data_out back).
- Serialises each accepted request into byte accesses on the 8-bit RAM/IO bus.
- Performs sign/zero extension for loads.
- Aborts loads on rob_clear; always completes stores already accepted.

---
 rtl/lsb_mem_responder.sv | 76 +++++++
 tb/tb_lsb_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_responder.sv
// lsb_mem_responder: serialises LSB load/store requests into byte accesses on an 8-bit RAM/IO bus
// Ports: clk_in/rst_in (async high) clock and reset; rdy_in global enable; rob_clear flush;
//   need_data/is_write/data_addr/data_in/work_type LSB request; data_handle accept pulse;
//   data_ready/data_out extended load result; mem_din/mem_dout/mem_a/mem_wr byte bus;
//   io_buffer_full stalls IO-region writes.
module lsb_mem_responder #(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              need_data,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_in,
  input  logic [2:0]        work_type,
  output logic              data_handle,
  output logic              data_ready,
  output logic [31:0]       data_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0] data, raw, ext;
  logic [2:0] kind, cnt, nb;
  logic [2:0][7:0] b;
  logic io_stall, last_rd, last_wr, accept;
  assign nb = kind[1] ? 3'd4 : kind[0] ? 3'd2 : 3'd1;
  assign io_stall = state == WRITE && addr[17:16] == IO_SEL && io_buffer_full;
  // cnt runs one past the last address in READ: the final byte arrives a cycle after it is addressed
  assign last_rd = state == READ && cnt == nb;
  assign last_wr = state == WRITE && !io_stall && cnt == nb - 3'd1;
  assign accept = (state == IDLE || last_rd || last_wr) && need_data && !rob_clear;
  assign mem_a = addr + ADDR_W'(cnt);
  assign mem_dout = data[{cnt[1:0], 3'b000} +: 8];
  assign mem_wr = state == WRITE && !io_stall && rdy_in;
  assign raw = nb == 3'd4 ? {mem_din, b[2], b[1], b[0]} : nb == 3'd2 ? {16'b0, mem_din, b[0]} : {24'b0, mem_din};
  assign ext = kind[1] ? raw : kind[0] ? {{16{raw[15] & ~kind[2]}}, raw[15:0]} : {{24{raw[7] & ~kind[2]}}, raw[7:0]};
  always_comb begin
    state_nx = state;
    if (accept) state_nx = is_write ? WRITE : READ;
    else if ((state == READ && (rob_clear || last_rd)) || last_wr) state_nx = IDLE;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nx;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cnt <= '0;
      addr <= '0;
      data <= '0;
      kind <= '0;
      b <= '0;
      data_handle <= 1'b0;
      data_ready <= 1'b0;
      data_out <= '0;
    end else if (rdy_in) begin
      cnt <= (accept || state_nx == IDLE) ? 3'd0 : (state == READ || (state == WRITE && !io_stall)) ? cnt + 3'd1 : cnt;
      data_handle <= accept;
      data_ready <= last_rd && !rob_clear;
      if (last_rd && !rob_clear) data_out <= ext;
      if (state == READ && cnt != 3'd0 && cnt != 3'd4) b[cnt[1:0] - 2'd1] <= mem_din;
      if (accept) begin
        addr <= data_addr;
        data <= data_in;
        kind <= work_type;
      end
    end
endmodule

// File: tb/tb_lsb_mem_responder.sv
// tb_lsb_mem_responder: directed and randomized checks of lsb_mem_responder against a byte-array model
module tb_lsb_mem_responder;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, rob_clear = 1'b0;
  logic need_data = 1'b0, is_write = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] data_addr = '0, data_in = '0, data_out, mem_a;
  logic [2:0] work_type = '0;
  logic data_handle, data_ready, mem_wr;
  logic [7:0] mem_din = '0, mem_dout;
  logic pk_en = 1'b0;
  logic [15:0] pk_a = '0;
  logic [7:0] pk_d = '0;
  bit [7:0] ram [65536];
  bit [7:0] mdl [65536];
  int n_cmp = 0, n_bad = 0;
  logic pend = 1'b0;
  logic [31:0] pend_val = '0;

  lsb_mem_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .need_data(need_data), .is_write(is_write), .data_addr(data_addr), .data_in(data_in),
    .work_type(work_type), .data_handle(data_handle), .data_ready(data_ready), .data_out(data_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    if (pk_en) ram[pk_a] <= pk_d;
  end

  function automatic int nbytes(input logic [2:0] t);
    return t[1] ? 4 : t[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] a, input logic [2:0] t);
    longint v = 0;
    int n = nbytes(t);
    for (int i = 0; i < n; i++) v += longint'(mdl[16'(a + i)]) << (8 * i);
    if (!t[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_in);
    pk_en = 1'b1; pk_a = a; pk_d = d; mdl[a] = d;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (pend) begin
      if (data_ready !== 1'b1 || data_out !== pend_val) begin
        n_bad++;
        $display("FAIL load_result ready=%b data=%h, need ready=1 data=%h", data_ready, data_out, pend_val);
      end
    end else if (data_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_ready data_ready=%b, need 0", data_ready);
    end
    pend = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] t, input bit clr);
    int n = nbytes(t);
    @(negedge clk_in);
    need_data = 1'b1; is_write = 1'b0; data_addr = a; work_type = t; data_in = $urandom;
    step();
    n_cmp++;
    if (data_handle !== 1'b1) begin n_bad++; $display("FAIL load_handle got %b need 1", data_handle); end
    need_data = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (clr && k == 1) rob_clear = 1'b1;
      #1;
      n_cmp++;
      if (mem_a !== a + k || mem_wr !== 1'b0) begin
        n_bad++;
        $display("FAIL load_bus c%0d a=%h wr=%b, need a=%h wr=0", k + 1, mem_a, mem_wr, a + k);
      end
      step();
      if (clr && k == 1) begin rob_clear = 1'b0; return; end
    end
    pend = 1'b1;
    pend_val = expect_load(a, t);
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                           input int stall, input bit frz, input bit clr);
    int n = nbytes(t);
    int st = stall;
    bit fz = frz;
    bit exp_wr;
    @(negedge clk_in);
    need_data = 1'b1; is_write = 1'b1; data_addr = a; work_type = t; data_in = d;
    step();
    n_cmp++;
    if (data_handle !== 1'b1) begin n_bad++; $display("FAIL store_handle got %b need 1", data_handle); end
    need_data = 1'b0;
    for (int k = 0; k < n;) begin
      io_buffer_full = st > 0;
      rdy_in = !(fz && k == 1);
      rob_clear = clr && k == 1;
      #1;
      exp_wr = rdy_in && st == 0;
      n_cmp++;
      if (mem_wr !== exp_wr) begin n_bad++; $display("FAIL store_wr byte%0d got %b need %b", k, mem_wr, exp_wr); end
      if (exp_wr) begin
        n_cmp++;
        if (mem_a !== a + k || mem_dout !== d[8 * k +: 8]) begin
          n_bad++;
          $display("FAIL store_bus byte%0d a=%h d=%h, need a=%h d=%h", k, mem_a, mem_dout, a + k, d[8 * k +: 8]);
        end
        mdl[16'(a + k)] = d[8 * k +: 8];
      end
      if (!rdy_in) fz = 1'b0;
      else if (st > 0) st--;
      else k++;
      if (k < n) step();
    end
    io_buffer_full = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({data_handle, data_ready, mem_wr} !== 3'b0 || data_out !== '0 || mem_a !== '0 || mem_dout !== '0) begin
      n_bad++;
      $display("FAIL %s h=%b r=%b wr=%b out=%h a=%h dout=%h, need all 0", tag, data_handle, data_ready, mem_wr, data_out, mem_a, mem_dout);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d = $urandom;
    check_zero("reset_state");
    @(negedge clk_in);
    rst_in = 1'b0;
    need_data = 1'b1; is_write = 1'b1; data_addr = 32'h500; data_in = d; work_type = 3'b010;
    step();
    n_cmp++;
    if (data_handle !== 1'b1) begin n_bad++; $display("FAIL reset_sw_handle got %b need 1", data_handle); end
    need_data = 1'b0;
    mdl[16'h500] = d[7:0];
    step();
    rst_in = 1'b1;
    #1;
    check_zero("reset_mid_write");
    @(negedge clk_in);
    rst_in = 1'b0;
    run_load(32'h100, 3'b010, 1'b0);
  endtask

  task automatic test_extend();
    run_load(32'h200, 3'b000, 1'b0);
    run_load(32'h200, 3'b100, 1'b0);
    run_load(32'h400, 3'b001, 1'b0);
    run_load(32'h400, 3'b101, 1'b0);
    step();
    n_cmp++;
    if (expect_load(32'h200, 3'b000) !== 32'hFFFFFF80 || expect_load(32'h400, 3'b101) !== 32'h00008001) begin
      n_bad++;
      $display("FAIL extend_model lb=%h lhu=%h, need ffffff80 00008001", expect_load(32'h200, 3'b000), expect_load(32'h400, 3'b101));
    end
  endtask

  task automatic test_back_to_back();
    run_store(32'h300, 32'h1234ABCD, 3'b001, 0, 1'b0, 1'b0);
    run_load(32'h300, 3'b010, 1'b0);
    run_load(32'h2FF, 3'b001, 1'b0);
    run_store(32'h310, $urandom, 3'b010, 0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_io_stall();
    run_store(32'h30000, 32'h41, 3'b000, 3, 1'b0, 1'b0);
    run_store(32'h30001, $urandom, 3'b001, 2, 1'b0, 1'b0);
    run_load(32'h30000, 3'b100, 1'b0);
    step();
  endtask

  task automatic test_rob_clear();
    run_load(32'h100, 3'b010, 1'b1);
    repeat (3) step();
    run_store(32'h600, 32'hDEADBEEF, 3'b010, 0, 1'b0, 1'b1);
    run_load(32'h600, 3'b010, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [2:0] lt [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a = $urandom_range(0, 32'hFF8);
      if ($urandom_range(0, 1) == 1) run_store(a, $urandom, 3'($urandom_range(0, 2)), 0, $urandom_range(0, 3) == 0, 1'b0);
      else run_load(a, lt[$urandom_range(0, 4)], 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) poke(16'(i), 8'($urandom));
    poke(16'h100, 8'h11); poke(16'h101, 8'h22); poke(16'h102, 8'h33); poke(16'h103, 8'h44);
    poke(16'h200, 8'h80); poke(16'h400, 8'h01); poke(16'h401, 8'h80);
    @(negedge clk_in);
    pk_en = 1'b0;
    test_reset();
    test_extend();
    test_back_to_back();
    test_io_stall();
    test_rob_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
